// File: rtl/duty_ramp_gen.sv
// duty_ramp_gen: prescaled triangular duty ramp with dwell at each extreme, for a downstream PWM stage.
module duty_ramp_gen #(
  parameter int unsigned STEP_DIV   = 8192,
  parameter int unsigned HOLD_STEPS = 16,
  parameter logic [7:0]  MIN_DUTY   = 8'd0,
  parameter logic [7:0]  MAX_DUTY   = 8'd255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic       restart,
  output logic [7:0] p,
  output logic       dir,
  output logic       step,
  output logic       peak
);
  localparam int unsigned PW = $clog2(STEP_DIV + 1);
  localparam logic [PW-1:0] CNT_LAST = PW'(STEP_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);
  localparam logic NO_HOLD = (HOLD_STEPS == 0);
  typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d, hold_q, hold_d;
  logic step_q, step_d, peak_q, peak_d, tick;
  assign tick = en && (cnt_q == CNT_LAST);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RISE;
      cnt_q   <= '0;
      p_q     <= MIN_DUTY;
      hold_q  <= '0;
      step_q  <= 1'b0;
      peak_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      peak_q  <= peak_d;
    end
  end
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    hold_d  = hold_q;
    cnt_d   = en ? (tick ? '0 : cnt_q + PW'(1)) : cnt_q;
    step_d  = tick;
    peak_d  = 1'b0;
    if (tick) begin
      case (state_q)
        RISE: begin
          if (p_q < MAX_DUTY) p_d = p_q + 8'd1;
          else begin
            state_d = NO_HOLD ? FALL : HOLD_HI;
            hold_d  = '0;
            peak_d  = 1'b1;
          end
        end
        HOLD_HI: begin
          if (hold_q == HOLD_LAST) state_d = FALL;
          else hold_d = hold_q + 8'd1;
        end
        FALL: begin
          if (p_q > MIN_DUTY) p_d = p_q - 8'd1;
          else begin
            state_d = NO_HOLD ? RISE : HOLD_LO;
            hold_d  = '0;
            peak_d  = 1'b1;
          end
        end
        HOLD_LO: begin
          if (hold_q == HOLD_LAST) state_d = RISE;
          else hold_d = hold_q + 8'd1;
        end
      endcase
    end
    // restart wins over a coincident tick
    if (restart) begin
      state_d = RISE;
      cnt_d   = '0;
      p_d     = MIN_DUTY;
      hold_d  = '0;
      step_d  = 1'b0;
      peak_d  = 1'b0;
    end
  end
  always_comb begin
    p    = p_q;
    dir  = (state_q == RISE) || (state_q == HOLD_HI);
    step = step_q;
    peak = peak_q;
  end
endmodule

// File: doc/duty_ramp_gen.md
DUTY_RAMP_GEN -- requirements
Module: duty_ramp_gen

Interface
REQ-001 Parameter STEP_DIV, default 8192: number of CLK cycles per ramp step; legal range 1..2^24.
REQ-002 Parameter HOLD_STEPS, default 16: number of extra steps the duty dwells at each extreme; legal range 0..255.
REQ-003 Parameter MIN_DUTY, default 0: lower duty bound, 8-bit.
REQ-004 Parameter MAX_DUTY, default 255: upper duty bound, 8-bit; MIN_DUTY < MAX_DUTY is required.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  high = ramp advances; low = ramp frozen.
REQ-008 restart  input  1  synchronous, single-cycle request to return to the reset state.
REQ-009 p  output  8  registered duty value for the downstream intensitateled PWM stage.
REQ-010 dir  output  1  1 = rising or high-hold phase, 0 = falling or low-hold phase.
REQ-011 step  output  1  one-cycle pulse, high during the cycle in which a step has just been taken.
REQ-012 peak  output  1  one-cycle pulse, high during the cycle in which a hold state has just been entered.

Function
REQ-013 Prescaler behaviour:
- counts 0..STEP_DIV-1 while en=1, then wraps to 0;
- "tick" is the clock edge at which it wraps;
- with STEP_DIV=1, every edge while en=1 is a tick.
REQ-014 When en=0, the prescaler, state, hold counter and p SHALL hold their values, and step and peak SHALL be 0.
REQ-015 The state machine SHALL have four states: RISE, HOLD_HI, FALL, HOLD_LO; all transitions occur only on ticks.
REQ-016 RISE on a tick:
- p<MAX_DUTY: p increments by 1;
- p==MAX_DUTY: go to HOLD_HI with hold counter cleared, or go directly to FALL if HOLD_STEPS==0; p unchanged.
REQ-017 HOLD_HI on a tick:
- hold counter==HOLD_STEPS-1: go to FALL;
- otherwise: hold counter increments; p unchanged.
REQ-018 FALL on a tick:
- p>MIN_DUTY: p decrements by 1;
- p==MIN_DUTY: go to HOLD_LO with hold counter cleared, or go directly to RISE if HOLD_STEPS==0; p unchanged.
REQ-019 HOLD_LO on a tick: mirrors HOLD_HI, exiting to RISE.
REQ-020 p SHALL never leave [MIN_DUTY, MAX_DUTY]; there is no 8-bit wrap-around at 0 or 255.
REQ-021 dir SHALL be 1 in RISE/HOLD_HI and 0 in FALL/HOLD_LO, registered together with the state.
REQ-022 step SHALL be 1 for exactly the one cycle following every tick edge, including ticks that do not change p.
REQ-023 peak SHALL be 1 for the one cycle following the edge that enters HOLD_HI or HOLD_LO, or that reverses direction directly when HOLD_STEPS==0.
REQ-024 Latency: the new p value is visible in the same cycle that step=1; no other cycle of latency exists.
REQ-025 restart=1 on an edge SHALL load the reset values of REQ-027, regardless of en; this takes priority over a coincident tick.
REQ-026 The output p SHALL change at most once per STEP_DIV cycles, so the downstream PWM never sees mid-step glitches.

Reset
REQ-027 While RST_N=0, regardless of CLK, the block SHALL hold:
- p=MIN_DUTY, dir=1, step=0, peak=0;
- state=RISE, prescaler=0, hold counter=0.
REQ-028 After RST_N deasserts, the first tick SHALL occur STEP_DIV enabled cycles later.
REQ-029 RST_N asserted mid-ramp or mid-hold SHALL immediately force the REQ-027 values, with no pending step completed.

Verification
All scenarios use STEP_DIV=4, HOLD_STEPS=2, MIN_DUTY=0, MAX_DUTY=3, and en=1 unless stated otherwise.
REQ-030 Reset release -> p steps 0,1,2,3 with step pulses on clocks 4, 8, 12; on clock 16, peak=1 with p=3 and dir=1.
REQ-031 Full cycle -> p leaves 3 on tick 7 (value 2), reaches 0 on tick 9, rises to 1 on tick 13; the period is 48 clocks with 2 peak pulses.
REQ-032 Drop en for 10 cycles while p=2 -> p, state and prescaler are frozen, with no step or peak; resuming gives the next tick after the remaining prescaler count.
REQ-033 Assert restart coincident with a tick while in HOLD_HI -> next cycle p=0, dir=1, step=0, peak=0.
REQ-034 HOLD_STEPS=0, MAX_DUTY=255 -> p runs 0..255..0 with no dwell ticks, never reaches 256 or -1, and peak pulses at 255 and 0.
REQ-035 Assert RST_N low asynchronously, between edges, while p=2 falling -> p=0 and dir=1 immediately, before the next CLK edge.
